// File: rtl/pico_io_pkg.sv
// Shared types and defaults for the switch input stage that sits between the
// board switches and the picomips core.
package pico_io_pkg;

  localparam int N_DEFAULT         = 8;
  localparam int DB_CYCLES_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE,
    VALID,
    WAIT_REL
  } state_t;

endpackage

// File: rtl/sw_input_stage_debounce.sv
// Single-bit debouncer. The stable value only flips after the input has
// disagreed with it for DB_CYCLES consecutive clocks.
module debounce #(
  parameter int DB_CYCLES = 4
) (
  input  logic clk,
  input  logic nReset,
  input  logic din,
  output logic stable
);

  localparam int            CW   = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);

  logic [CW-1:0] cnt;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the pre-edge values.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      cnt    <= '0;
      stable <= 1'b0;
    end else if (din == stable) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      stable <= din;
      cnt    <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sw_input_stage.sv
// Synchronises and debounces the board switches and hands one captured data
// byte at a time to the processor using a valid/ack handshake.
module sw_input_stage
  import pico_io_pkg::*;
#(
  parameter int N         = N_DEFAULT,
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input  logic         clk,
  input  logic         nReset,
  input  logic [9:0]   SW,
  input  logic         ack,
  output logic [N-1:0] data_out,
  output logic         data_valid,
  output logic         mode,
  output logic         overrun
);

  logic [9:0] sync1, sync2;
  logic       db_load, db_mode, db_load_q;
  logic       load_evt, capture, set_overrun;
  state_t     state, next_state;

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= SW;
      sync2 <= sync1;
    end
  end

  debounce #(.DB_CYCLES(DB_CYCLES)) u_db_load (
    .clk(clk), .nReset(nReset), .din(sync2[8]), .stable(db_load)
  );

  debounce #(.DB_CYCLES(DB_CYCLES)) u_db_mode (
    .clk(clk), .nReset(nReset), .din(sync2[9]), .stable(db_mode)
  );

  assign load_evt = db_load & ~db_load_q;

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    next_state  = state;
    capture     = 1'b0;
    set_overrun = 1'b0;
    unique case (state)
      IDLE: begin
        if (load_evt) begin
          next_state = VALID;
          capture    = 1'b1;
        end
      end
      VALID: begin
        // ack takes priority; a simultaneous press is still flagged as an overrun
        set_overrun = load_evt;
        if (ack) next_state = WAIT_REL;
      end
      WAIT_REL: begin
        if (!db_load) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state     <= IDLE;
      db_load_q <= 1'b0;
      data_out  <= '0;
      overrun   <= 1'b0;
      mode      <= 1'b0;
    end else begin
      state     <= next_state;
      db_load_q <= db_load;
      mode      <= db_mode;
      if (capture)     data_out <= sync2[N-1:0];
      if (set_overrun) overrun  <= 1'b1;
    end
  end

  assign data_valid = (state == VALID);

endmodule

// File: tb/tb_sw_input_stage.sv
// Directed bench for sw_input_stage: captures are scoreboarded (data and
// arrival cycle) by an independent monitor; other behaviour is checked inline.
module tb_sw_input_stage;

  localparam int N  = 8;
  localparam int DB = 4;
  localparam int LAT = 2 + DB + 1;

  typedef struct {
    logic [N-1:0] data;
    int           cycle;
  } exp_t;

  logic         clk = 1'b0;
  logic         nReset = 1'b0;
  logic [9:0]   SW = '0;
  logic         ack = 1'b0;
  logic [N-1:0] data_out;
  logic         data_valid, mode, overrun;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];

  sw_input_stage #(.N(N), .DB_CYCLES(DB)) dut (
    .clk(clk), .nReset(nReset), .SW(SW), .ack(ack),
    .data_out(data_out), .data_valid(data_valid), .mode(mode), .overrun(overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [N-1:0] d);
    exp_t e;
    e.data  = d;
    e.cycle = cyc + LAT;
    sb.push_back(e);
  endtask

  task automatic wait_dv(input int budget);
    int k = 0;
    while (!data_valid && k < budget) begin
      tick(1);
      k++;
    end
    if (!data_valid) check("wait_dv_timeout", 32'(data_valid), 32'd1);
  endtask

  task automatic ack_pulse();
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    check("dv_after_ack", 32'(data_valid), 32'd0);
  endtask

  // Monitor: every rising data_valid must match the next scoreboard entry,
  // and data_out must not move while data_valid stays high.
  logic         prev_dv = 1'b0;
  logic [N-1:0] held = '0;
  always @(negedge clk) begin
    if (data_valid && !prev_dv) begin
      if (sb.size() == 0) begin
        check("unexpected_capture", 32'(data_valid), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("capture_data", 32'(data_out), 32'(e.data));
        check("capture_cycle", 32'(cyc), 32'(e.cycle));
      end
      held = data_out;
    end else if (data_valid && prev_dv) begin
      if (data_out !== held) check("data_frozen", 32'(data_out), 32'(held));
    end
    prev_dv = data_valid;
  end

  initial begin
    // Reset state
    tick(2);
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_dv", 32'(data_valid), 32'd0);
    check("rst_mode", 32'(mode), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    nReset = 1'b1;
    tick(2);

    // Basic capture of A5 with exact latency, then ack
    SW = 10'h1A5;
    push(8'hA5);
    wait_dv(20);
    tick(1);
    ack_pulse();
    SW[8] = 1'b0;
    tick(10);

    // Short bounce on the load switch must not capture
    SW[7:0] = 8'h77;
    SW[8] = 1'b1;
    tick(3);
    SW[8] = 1'b0;
    tick(12);
    check("bounce_dv", 32'(data_valid), 32'd0);
    check("bounce_overrun", 32'(overrun), 32'd0);

    // Capture 3C, then a second press while VALID -> overrun, data held
    SW = 10'h13C;
    push(8'h3C);
    wait_dv(20);
    SW[8] = 1'b0;
    tick(6);
    SW = 10'h1FF;
    tick(8);
    check("ovr_set", 32'(overrun), 32'd1);
    check("ovr_data_held", 32'(data_out), 32'h3C);
    check("ovr_dv", 32'(data_valid), 32'd1);

    // Ack with switch still high -> WAIT_REL; release, then capture 12
    ack_pulse();
    tick(4);
    check("wait_rel_dv", 32'(data_valid), 32'd0);
    SW[8] = 1'b0;
    tick(10);
    SW = 10'h112;
    push(8'h12);
    wait_dv(20);
    check("ovr_sticky", 32'(overrun), 32'd1);
    tick(1);
    ack_pulse();
    SW[8] = 1'b0;
    tick(10);

    // Reset mid-VALID with 5A held, switch kept high -> recapture after release
    SW = 10'h15A;
    push(8'h5A);
    wait_dv(20);
    tick(1);
    #2 nReset = 1'b0;
    #1;
    check("midrst_dv", 32'(data_valid), 32'd0);
    check("midrst_data", 32'(data_out), 32'd0);
    check("midrst_overrun", 32'(overrun), 32'd0);
    check("midrst_mode", 32'(mode), 32'd0);
    tick(2);
    nReset = 1'b1;
    push(8'h5A);
    wait_dv(20);
    check("post_rst_overrun", 32'(overrun), 32'd0);

    // Mode: 2-cycle glitch ignored, held level appears after LAT cycles
    SW[9] = 1'b1;
    tick(2);
    SW[9] = 1'b0;
    tick(10);
    check("mode_glitch", 32'(mode), 32'd0);
    SW[9] = 1'b1;
    tick(LAT - 1);
    check("mode_early", 32'(mode), 32'd0);
    tick(1);
    check("mode_set", 32'(mode), 32'd1);
    ack_pulse();
    SW[8] = 1'b0;
    tick(10);
    check("mode_hold", 32'(mode), 32'd1);
    check("end_dv", 32'(data_valid), 32'd0);

    tick(2);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
